// File: rtl/eq_seq_ctrl.sv
// -----------------------------------------------------------------------------
// eq_seq_ctrl
//   Sequencer for an equalizer FIR + slicer datapath.  After a start request it
//   loads FIR_LEN coefficients over a valid/ready stream, flushes the delay
//   line with FIR_LEN forced-zero samples, runs on live symbols until a stop
//   request, then drains the pipeline for LATENCY cycles so that symbols
//   accepted at the end of RUN still come out of the slicer.
//
//   Optional feature: define EQ_SEQ_CTRL_SYMCNT_EN to build the saturating
//   symbol counter on o_sym_count; without it o_sym_count is tied to zero.
//
// Ports
//   i_clock         rising-edge clock
//   i_reset         asynchronous active-low reset
//   i_start         start request (only honoured in IDLE)
//   i_stop          stop request (LOAD/FLUSH: abort, RUN: drain)
//   i_coeff_valid   coefficient word present on i_coeff
//   i_coeff         coefficient word
//   o_coeff_ready   high while in LOAD
//   o_coeff_we      registered coefficient write strobe
//   o_coeff_addr    registered coefficient write address
//   o_coeff_data    registered coefficient write data
//   i_sample_valid  upstream symbol available
//   o_fir_en        FIR/slicer enable
//   o_fir_valid     FIR input valid
//   o_zero_sel      select zero sample instead of the upstream symbol
//   o_out_valid     slicer output holds a real symbol decision
//   o_state         current state encoding (IDLE=0 .. DRAIN=4)
//   o_busy          not in IDLE
//   o_done          one-cycle pulse after a completed drain
//   o_abort         one-cycle pulse after a stop in LOAD/FLUSH
//   o_sym_count     number of real symbol decisions (saturating)
// -----------------------------------------------------------------------------
module eq_seq_ctrl #(
    parameter int FIR_LEN  = 21,
    parameter int NB_COEFF = 8,
    parameter int LATENCY  = 2,
    parameter int NB_CNT   = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_coeff_valid,
    input  logic [NB_COEFF-1:0] i_coeff,
    output logic                o_coeff_ready,
    output logic                o_coeff_we,
    output logic [4:0]          o_coeff_addr,
    output logic [NB_COEFF-1:0] o_coeff_data,
    input  logic                i_sample_valid,
    output logic                o_fir_en,
    output logic                o_fir_valid,
    output logic                o_zero_sel,
    output logic                o_out_valid,
    output logic [2:0]          o_state,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_abort,
    output logic [NB_CNT-1:0]   o_sym_count
);

    // One phase counter serves both FLUSH (FIR_LEN cycles) and DRAIN
    // (LATENCY cycles), so it is sized for the longer of the two.
    localparam int CNT_MAX = (FIR_LEN > LATENCY) ? FIR_LEN : LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] FLUSH_LAST  = CW'(FIR_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(LATENCY - 1);
    localparam logic [4:0]    IDX_LAST    = 5'(FIR_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [4:0]            r_idx;
    logic [CW-1:0]         r_cnt;
    logic [LATENCY-1:0]    r_vsr;
    logic                  r_coeff_we;
    logic [4:0]            r_coeff_addr;
    logic [NB_COEFF-1:0]   r_coeff_data;
    logic                  r_done;
    logic                  r_abort;

    logic w_accept;
    logic w_start;
    logic w_abort;
    logic w_done;
    logic w_real;
    logic w_enter_idle;

    assign w_accept     = (r_state == S_LOAD) && i_coeff_valid;
    assign w_start      = (r_state == S_IDLE) && i_start && !i_stop;
    assign w_done       = (r_state == S_DRAIN) && (r_cnt == DRAIN_LAST);
    assign w_enter_idle = (w_state_next == S_IDLE) && (r_state != S_IDLE);
    // Only live symbols (not flush/drain zeros) become real decisions.
    assign w_real       = o_fir_valid && !o_zero_sel;

    // -------------------------------------------------------------------------
    // Next state and datapath controls
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        o_coeff_ready = 1'b0;
        o_fir_en      = 1'b0;
        o_fir_valid   = 1'b0;
        o_zero_sel    = 1'b0;
        w_abort       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                o_coeff_ready = 1'b1;
                // A word offered together with stop is still written: the
                // handshake completed, and issued writes are never retracted.
                if (i_stop) begin
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                end else if (w_accept && (r_idx == IDX_LAST)) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                o_fir_en    = 1'b1;
                o_fir_valid = 1'b1;
                o_zero_sel  = 1'b1;
                if (i_stop) begin
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                end else if (r_cnt == FLUSH_LAST) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                o_fir_en    = 1'b1;
                o_fir_valid = i_sample_valid;
                if (i_stop) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_fir_en    = 1'b1;
                o_fir_valid = 1'b1;
                o_zero_sel  = 1'b1;
                if (r_cnt == DRAIN_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters, coefficient write port, status pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_vsr        <= '0;
            r_coeff_we   <= 1'b0;
            r_coeff_addr <= '0;
            r_coeff_data <= '0;
            r_done       <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_state <= w_state_next;

            r_coeff_we <= w_accept;
            if (w_accept) begin
                r_coeff_addr <= r_idx;
                r_coeff_data <= i_coeff;
            end

            if (w_start) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + 5'd1;
            end

            // Restart the phase counter on every state change so FLUSH and
            // DRAIN each begin counting from zero.
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_FLUSH) || (r_state == S_DRAIN)) begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            if (w_enter_idle) begin
                r_vsr <= '0;
            end else begin
                for (int i = LATENCY - 1; i > 0; i--) begin
                    r_vsr[i] <= r_vsr[i-1];
                end
                r_vsr[0] <= w_real;
            end

            r_done  <= w_done;
            r_abort <= w_abort;
        end
    end

    // -------------------------------------------------------------------------
    // Optional saturating symbol counter
    // -------------------------------------------------------------------------
`ifdef EQ_SEQ_CTRL_SYMCNT_EN
    localparam logic [NB_CNT-1:0] SYM_ONE = NB_CNT'(1);
    logic [NB_CNT-1:0] r_sym_cnt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sym_cnt <= '0;
        end else if (w_start) begin
            r_sym_cnt <= '0;
        end else if (o_out_valid && (r_sym_cnt != '1)) begin
            r_sym_cnt <= r_sym_cnt + SYM_ONE;
        end
    end

    assign o_sym_count = r_sym_cnt;
`else
    assign o_sym_count = '0;
`endif

    assign o_state      = r_state;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_abort      = r_abort;
    assign o_coeff_we   = r_coeff_we;
    assign o_coeff_addr = r_coeff_addr;
    assign o_coeff_data = r_coeff_data;
    assign o_out_valid  = r_vsr[LATENCY-1];

endmodule

// File: doc/eq_seq_ctrl.md
EQ_SEQ_CTRL -- requirements
Module: eq_seq_ctrl

Interface
REQ-001 Parameter FIR_LEN, default 21: number of FIR taps (coefficients to load, zeros to flush).
REQ-002 Parameter NB_COEFF, default 8: coefficient word width.
REQ-003 Parameter LATENCY, default 2: cycles from an accepted FIR input to a valid slicer output.
REQ-004 Parameter NB_CNT, default 16: symbol counter width.
REQ-005 Port i_clock  in  1: single clock; all state changes on its rising edge.
REQ-006 Port i_reset  in  1: asynchronous, active-low reset.
REQ-007 Port i_start  in  1: start request, sampled in IDLE only.
REQ-008 Port i_stop  in  1: stop request.
REQ-009 Port i_coeff_valid  in  1, i_coeff  in  NB_COEFF: coefficient stream with valid/ready handshake.
REQ-010 Port o_coeff_ready  out  1: high exactly while in LOAD.
REQ-011 Ports o_coeff_we  out  1, o_coeff_addr  out  5, o_coeff_data  out  NB_COEFF: registered FIR coefficient write port.
REQ-012 Port i_sample_valid  in  1: upstream symbol available this cycle.
REQ-013 Ports o_fir_en  out  1, o_fir_valid  out  1, o_zero_sel  out  1: FIR/slicer enable, valid, and force-zero sample mux select.
REQ-014 Port o_out_valid  out  1: slicer output holds a real symbol decision this cycle.
REQ-015 Ports o_state  out  3, o_busy  out  1, o_done  out  1, o_abort  out  1, o_sym_count  out  NB_CNT: status.

Function
REQ-016 The block SHALL implement states IDLE=0, LOAD=1, FLUSH=2, RUN=3, DRAIN=4; o_state SHALL equal the current encoding; o_busy SHALL be high in every state except IDLE.
REQ-017 IDLE: o_fir_en, o_fir_valid, o_zero_sel, o_coeff_ready all 0; i_start=1 and i_stop=0 -> LOAD, clear coefficient index and o_sym_count; i_start together with i_stop -> stay IDLE.
REQ-018 LOAD: each cycle with i_coeff_valid=1, the next cycle SHALL show o_coeff_we=1, o_coeff_addr=index, o_coeff_data=i_coeff; index increments; acceptance of the FIR_LEN-th word -> FLUSH in the same edge.
REQ-019 FLUSH: o_fir_en=1, o_fir_valid=1, o_zero_sel=1 for exactly FIR_LEN cycles, then RUN.
REQ-020 RUN: o_fir_en=1, o_zero_sel=0, o_fir_valid=i_sample_valid (combinational pass-through); i_stop=1 -> DRAIN.
REQ-021 DRAIN: o_fir_en=1, o_fir_valid=1, o_zero_sel=1 for exactly LATENCY cycles; o_done SHALL pulse high for one cycle on the DRAIN->IDLE transition.
REQ-022 i_stop in LOAD or FLUSH SHALL go to IDLE on the next edge with a one-cycle o_abort pulse, without o_done; coefficient writes already issued are not retracted.
REQ-023 i_start outside IDLE SHALL be ignored.
REQ-024 o_out_valid SHALL equal (o_fir_valid AND NOT o_zero_sel) delayed by exactly LATENCY cycles through a shift register cleared on entry to IDLE.
REQ-025 Real symbols accepted in the last LATENCY RUN cycles SHALL still produce o_out_valid during DRAIN.
REQ-026 o_sym_count SHALL increment on each o_out_valid and saturate at 2^NB_CNT-1 without wrapping.

Reset
REQ-027 While i_reset=0: state=IDLE, index=0, valid shift register=0, o_coeff_we=0, o_coeff_addr=0, o_coeff_data=0, o_done=0, o_abort=0, o_sym_count=0; all outputs SHALL take their IDLE values immediately, independent of the clock.
REQ-028 Reset asserted in any state SHALL abandon the operation without o_done or o_abort.

Configuration
REQ-029 Macro EQ_SEQ_CTRL_SYMCNT_EN defined: o_sym_count behaves per REQ-026.
REQ-030 Macro undefined: no counter logic; o_sym_count SHALL be constant 0; all other behaviour unchanged.

Verification
REQ-031 Reset low mid-RUN -> o_state=0, o_fir_en=0, o_out_valid=0 before next clock edge.
REQ-032 i_start, then 21 coefficients 0x01..0x15 with i_coeff_valid gapped every 3rd cycle -> writes addr 0..20 with data 0x01..0x15 in order, FLUSH lasts exactly 21 cycles with o_zero_sel=1.
REQ-033 RUN with i_sample_valid pattern 1,1,0,1 -> o_out_valid pattern 1,1,0,1 starting 2 cycles later; o_sym_count=3 (macro defined), 0 (macro undefined).
REQ-034 i_stop on the same cycle as the final real symbol -> DRAIN lasts 2 cycles, final o_out_valid in last DRAIN cycle, o_done one cycle, then IDLE.
REQ-035 i_stop after 10 coefficients accepted -> IDLE next edge, o_abort one cycle, o_done stays 0; i_start and i_stop together in IDLE -> remains IDLE.
REQ-036 NB_CNT=4, 20 real symbols in RUN -> o_sym_count saturates and holds at 15.
